// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline control/payload types for the ID->EX boundary
package rv_pipe_pkg;
   localparam int P_XLEN       = 32;
   localparam int P_IMM_W      = 32;
   localparam int P_REG_ADDR_W = 5;
   localparam int P_FUNCT7_W   = 7;
   typedef enum logic [1:0] {SRC_RS = 2'd0, SRC_PC = 2'd1, SRC_IMM = 2'd2, SRC_ZERO = 2'd3} alu_src_e;
   typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FN = 2'd2, ALU_BR = 2'd3} alu_op_e;
   typedef struct packed {
      alu_src_e aluSrc1;
      alu_src_e aluSrc2;
      alu_op_e  aluOp;
      logic     memWrite;
      logic     memRead;
      logic     regWrite;
      logic     memToReg;
   } ctrl_t;
   typedef struct packed {
      ctrl_t                   ctrl;
      logic [P_FUNCT7_W-1:0]   funct7;
      logic [2:0]              funct3;
      logic [P_XLEN-1:0]       read1;
      logic [P_XLEN-1:0]       read2;
      logic [P_IMM_W-1:0]      imm_i;
      logic [P_IMM_W-1:0]      imm_s;
      logic [P_IMM_W-1:0]      imm_u;
      logic [P_REG_ADDR_W-1:0] rd;
      logic [P_REG_ADDR_W-1:0] rs1;
      logic [P_REG_ADDR_W-1:0] rs2;
   } id_ex_payload_t;
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: generic 2-entry valid/ready skid buffer with registered upstream ready
module pipe_skid_buffer #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic i_flush,
   input  logic i_valid,
   output logic o_ready,
   input  T     i_data,
   output logic o_valid,
   input  logic i_ready,
   output T     o_data
);
   localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
   logic [1:0] r_state, w_nxt;
   logic       r_ready, w_acc, w_pop;
   T           r_main, r_skid;
   assign w_acc   = i_valid & r_ready;
   assign w_pop   = (r_state != EMPTY) & i_ready;
   assign o_ready = r_ready;
   assign o_valid = r_state != EMPTY;
   assign o_data  = r_main;
   always_comb
      w_nxt = i_flush ? EMPTY :
              r_state == EMPTY ? (w_acc ? ONE : EMPTY) :
              r_state == ONE ? (w_pop ? (w_acc ? ONE : EMPTY) : (w_acc ? FULL : ONE)) :
              (w_pop ? ONE : FULL);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= EMPTY;
         r_ready <= 1'b0;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_nxt;
         r_ready <= w_nxt != FULL;
         if ((r_state == EMPTY && w_acc) || (r_state == ONE && w_pop && w_acc))
            r_main <= i_data;
         else if (r_state != EMPTY && r_state != ONE && w_pop)
            r_main <= r_skid;
         if (r_state == ONE && !w_pop && w_acc)
            r_skid <= i_data;
      end
   end
endmodule

// File: rtl/id_ex_stage_buffer.sv
// id_ex_stage_buffer: ID->EX payload register with skid storage, flush, x0 write squash and bubble gating
module id_ex_stage_buffer import rv_pipe_pkg::*; #(
   parameter int XLEN         = P_XLEN,
   parameter int IMM_W        = P_IMM_W,
   parameter int REG_ADDR_W   = P_REG_ADDR_W,
   parameter int FUNCT7_W     = P_FUNCT7_W,
   parameter bit SQUASH_X0_WR = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  id_valid,
   output logic                  id_ready,
   input  ctrl_t                 id_ctrl,
   input  logic [FUNCT7_W-1:0]   id_funct7,
   input  logic [2:0]            id_funct3,
   input  logic [XLEN-1:0]       id_read1,
   input  logic [XLEN-1:0]       id_read2,
   input  logic [IMM_W-1:0]      id_imm_i,
   input  logic [IMM_W-1:0]      id_imm_s,
   input  logic [IMM_W-1:0]      id_imm_u,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   output logic                  ex_valid,
   input  logic                  ex_ready,
   output ctrl_t                 ex_ctrl,
   output logic [FUNCT7_W-1:0]   ex_funct7,
   output logic [2:0]            ex_funct3,
   output logic [XLEN-1:0]       ex_read1,
   output logic [XLEN-1:0]       ex_read2,
   output logic [IMM_W-1:0]      ex_imm_i,
   output logic [IMM_W-1:0]      ex_imm_s,
   output logic [IMM_W-1:0]      ex_imm_u,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [REG_ADDR_W-1:0] ex_rs1,
   output logic [REG_ADDR_W-1:0] ex_rs2
);
   id_ex_payload_t w_d, w_q;
   logic           w_v;
   always_comb begin
      w_d = '{ctrl: id_ctrl, funct7: id_funct7, funct3: id_funct3, read1: id_read1, read2: id_read2,
              imm_i: id_imm_i, imm_s: id_imm_s, imm_u: id_imm_u, rd: id_rd, rs1: id_rs1, rs2: id_rs2};
      w_d.ctrl.regWrite = id_ctrl.regWrite & (!SQUASH_X0_WR || id_rd != '0);
   end
   pipe_skid_buffer #(.T(id_ex_payload_t)) u_skid (
      .clk(clk), .rst(rst), .i_flush(flush),
      .i_valid(id_valid), .o_ready(id_ready), .i_data(w_d),
      .o_valid(w_v), .i_ready(ex_ready), .o_data(w_q)
   );
   // side-effecting controls are masked so a bubble can never write memory or the regfile
   always_comb begin
      ex_ctrl          = w_q.ctrl;
      ex_ctrl.memWrite = w_q.ctrl.memWrite & w_v;
      ex_ctrl.memRead  = w_q.ctrl.memRead & w_v;
      ex_ctrl.regWrite = w_q.ctrl.regWrite & w_v;
      ex_ctrl.memToReg = w_q.ctrl.memToReg & w_v;
   end
   assign ex_valid  = w_v;
   assign ex_funct7 = w_q.funct7;
   assign ex_funct3 = w_q.funct3;
   assign ex_read1  = w_q.read1;
   assign ex_read2  = w_q.read2;
   assign ex_imm_i  = w_q.imm_i;
   assign ex_imm_s  = w_q.imm_s;
   assign ex_imm_u  = w_q.imm_u;
   assign ex_rd     = w_q.rd;
   assign ex_rs1    = w_q.rs1;
   assign ex_rs2    = w_q.rs2;
endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// tb_id_ex_stage_buffer: queue-based scoreboard for id_ex_stage_buffer, squash on and off builds
module tb_id_ex_stage_buffer;
   import rv_pipe_pkg::*;
   typedef struct {id_ex_payload_t p; logic rw0;} exp_t;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, id_valid = 1'b0, ex_ready = 1'b0;
   id_ex_payload_t din = '0;
   logic id_ready, ex_valid, id_ready0, ex_valid0;
   ctrl_t ex_ctrl, ex_ctrl0;
   logic [6:0] ex_funct7, ex_funct7_0;
   logic [2:0] ex_funct3, ex_funct3_0;
   logic [31:0] ex_read1, ex_read2, ex_imm_i, ex_imm_s, ex_imm_u;
   logic [31:0] ex_read1_0, ex_read2_0, ex_imm_i0, ex_imm_s0, ex_imm_u0;
   logic [4:0] ex_rd, ex_rs1, ex_rs2, ex_rd0, ex_rs1_0, ex_rs2_0;
   id_ex_payload_t act, act0, e0;
   exp_t q[$];
   int tests = 0, fails = 0, mon_n;
   bit mon_en = 1'b0, new_push = 1'b0;
   always #5 clk = ~clk;
   id_ex_stage_buffer dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
      .id_ctrl(din.ctrl), .id_funct7(din.funct7), .id_funct3(din.funct3), .id_read1(din.read1),
      .id_read2(din.read2), .id_imm_i(din.imm_i), .id_imm_s(din.imm_s), .id_imm_u(din.imm_u),
      .id_rd(din.rd), .id_rs1(din.rs1), .id_rs2(din.rs2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl), .ex_funct7(ex_funct7),
      .ex_funct3(ex_funct3), .ex_read1(ex_read1), .ex_read2(ex_read2), .ex_imm_i(ex_imm_i),
      .ex_imm_s(ex_imm_s), .ex_imm_u(ex_imm_u), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2)
   );
   id_ex_stage_buffer #(.SQUASH_X0_WR(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready0),
      .id_ctrl(din.ctrl), .id_funct7(din.funct7), .id_funct3(din.funct3), .id_read1(din.read1),
      .id_read2(din.read2), .id_imm_i(din.imm_i), .id_imm_s(din.imm_s), .id_imm_u(din.imm_u),
      .id_rd(din.rd), .id_rs1(din.rs1), .id_rs2(din.rs2),
      .ex_valid(ex_valid0), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl0), .ex_funct7(ex_funct7_0),
      .ex_funct3(ex_funct3_0), .ex_read1(ex_read1_0), .ex_read2(ex_read2_0), .ex_imm_i(ex_imm_i0),
      .ex_imm_s(ex_imm_s0), .ex_imm_u(ex_imm_u0), .ex_rd(ex_rd0), .ex_rs1(ex_rs1_0), .ex_rs2(ex_rs2_0)
   );
   assign act  = {ex_ctrl, ex_funct7, ex_funct3, ex_read1, ex_read2, ex_imm_i, ex_imm_s, ex_imm_u,
                  ex_rd, ex_rs1, ex_rs2};
   assign act0 = {ex_ctrl0, ex_funct7_0, ex_funct3_0, ex_read1_0, ex_read2_0, ex_imm_i0, ex_imm_s0,
                  ex_imm_u0, ex_rd0, ex_rs1_0, ex_rs2_0};
   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   function automatic id_ex_payload_t rnd_item(input int rd);
      logic [255:0] t;
      id_ex_payload_t p;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      p = id_ex_payload_t'(t[$bits(id_ex_payload_t)-1:0]);
      if (rd >= 0) p.rd = 5'(rd);
      return p;
   endfunction
   // issue one cycle of stimulus; an accepted, unflushed instruction becomes expected EX output
   task automatic step(input bit v, input bit r, input bit f, input id_ex_payload_t p);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = v;
      ex_ready = r;
      flush    = f;
      din      = p;
      new_push = v && id_ready && !f;
      if (new_push) begin
         e.p = p;
         e.p.ctrl.regWrite = p.ctrl.regWrite && (p.rd != 5'd0);
         e.rw0 = p.ctrl.regWrite;
         q.push_back(e);
      end
   endtask
   always @(negedge clk) if (mon_en) begin
      mon_n = q.size() - int'(new_push);
      chk("ex_valid", ex_valid, mon_n > 0);
      chk("id_ready", id_ready, mon_n < 2);
      chk("ex_valid_nosq", ex_valid0, mon_n > 0);
      if (ex_valid && mon_n > 0) begin
         chk("payload", act, q[0].p);
         e0 = q[0].p;
         e0.ctrl.regWrite = q[0].rw0;
         chk("payload_nosq", act0, e0);
      end else if (!ex_valid)
         chk("bubble", {ex_ctrl.memWrite, ex_ctrl.memRead, ex_ctrl.regWrite, ex_ctrl.memToReg}, 0);
      if (flush) q.delete();
      else if (ex_valid && ex_ready && mon_n > 0) void'(q.pop_front());
   end
   initial begin
      id_ex_payload_t p;
      bit acc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_id_ready", id_ready, 0);
      chk("rst_ex_all", {act, act0}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", id_ready, 1);
      mon_en = 1'b1;
      for (int i = 1; i <= 8; i++) step(1, 1, 0, rnd_item(i));
      step(0, 1, 0, rnd_item(-1));
      step(0, 1, 0, rnd_item(-1));
      for (int i = 1; i <= 3; i++) step(1, 0, 0, rnd_item(i));
      chk("bp_full_ready", id_ready, 0);
      p = rnd_item(3);
      acc = 1'b0;
      for (int k = 0; k < 6 && !acc; k++) begin
         step(1, k > 0, 0, p);
         acc = new_push;
      end
      chk("bp_third_accepted", acc, 1);
      repeat (3) step(0, 1, 0, rnd_item(-1));
      step(1, 0, 0, rnd_item(10));
      step(1, 0, 0, rnd_item(11));
      step(1, 0, 1, rnd_item(12));
      step(0, 0, 0, rnd_item(-1));
      chk("flush_empty", ex_valid, 0);
      p = rnd_item(5);
      p.ctrl.regWrite = 1'b1;
      p.ctrl.memWrite = 1'b1;
      step(1, 1, 0, p);
      step(0, 1, 0, rnd_item(-1));
      step(0, 1, 0, rnd_item(-1));
      chk("bubble_regwrite", ex_ctrl.regWrite, 0);
      p = rnd_item(0);
      p.ctrl.regWrite = 1'b1;
      step(1, 0, 0, p);
      step(0, 0, 0, rnd_item(-1));
      @(negedge clk);
      chk("x0_squash", ex_ctrl.regWrite, 0);
      chk("x0_nosquash", ex_ctrl0.regWrite, 1);
      step(0, 1, 0, rnd_item(-1));
      for (int i = 0; i < 3000; i++)
         step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6, $urandom_range(19, 0) == 0,
              rnd_item($urandom_range(3, 0) == 0 ? 0 : -1));
      repeat (4) step(0, 1, 0, rnd_item(-1));
      @(negedge clk);
      mon_en = 1'b0;
      chk("drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
